// File: rtl/line_fill_mem.sv
// Backing-store controller under the OtterMemory data cache: line fills and writebacks as fixed-length bursts.
// Define CRITICAL_WORD_FIRST_EN to make read bursts start at the requested word and wrap around the line.

module line_fill_mem #(
  parameter int  WORDS_PER_LINE = 8,
  parameter int  LATENCY        = 4,
  parameter int  MEM_WORDS      = 16384,
  localparam int IDX_W          = $clog2(WORDS_PER_LINE)
) (
  input  logic             MEM_CLK,
  input  logic             MEM_RST_N,
  input  logic             REQ_VALID,
  output logic             REQ_READY,
  input  logic             REQ_WE,
  input  logic [31:0]      REQ_ADDR,
  output logic             WR_REQ,
  output logic [IDX_W-1:0] WR_IDX,
  input  logic [31:0]      WR_DATA,
  output logic             RD_VALID,
  output logic [IDX_W-1:0] RD_IDX,
  output logic [31:0]      RD_DATA,
  output logic             DONE,
  output logic             ERR
);

  localparam int AW = $clog2(MEM_WORDS);
  localparam int LW = AW - IDX_W;
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_BURST,
    ST_ERROR
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    wait_q, wait_d;
  logic [IDX_W-1:0] beat_q, beat_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [LW-1:0]    line_q;
  logic             we_q;
  logic             rd_valid_q;
  logic [IDX_W-1:0] rd_idx_q;
  logic [31:0]      ram_q;
  logic [31:0]      mem [MEM_WORDS];

  logic             req_fire;
  logic             req_oor;
  logic [LW-1:0]    req_line;
  logic [LW-1:0]    cur_line;
  logic             cur_we;
  logic [IDX_W-1:0] start_idx;
  logic             last_beat;
  logic             rd_load;
  logic             wr_en;

  assign req_fire = REQ_VALID && (state_q == ST_IDLE);
  // Range is judged on the full line base, so addresses that alias into the array are still rejected.
  assign req_oor  = {2'b00, REQ_ADDR[31:IDX_W+2], {IDX_W{1'b0}}} >= 32'(MEM_WORDS);
  assign req_line = REQ_ADDR[AW+1:IDX_W+2];

  // In IDLE the burst may start on the acceptance edge (zero latency), so use the live request.
  assign cur_line  = (state_q == ST_IDLE) ? req_line : line_q;
  assign cur_we    = (state_q == ST_IDLE) ? REQ_WE : we_q;
  assign last_beat = (beat_q == IDX_W'(WORDS_PER_LINE - 1));

`ifdef CRITICAL_WORD_FIRST_EN
  logic [IDX_W-1:0] off_q;
  logic [IDX_W-1:0] cur_off;
  logic             unused_addr;

  assign cur_off     = (state_q == ST_IDLE) ? REQ_ADDR[IDX_W+1:2] : off_q;
  assign start_idx   = cur_we ? '0 : cur_off;
  assign unused_addr = ^REQ_ADDR[1:0];

  always_ff @(posedge MEM_CLK or negedge MEM_RST_N) begin
    if (!MEM_RST_N) begin
      off_q <= '0;
    end else if (req_fire) begin
      off_q <= REQ_ADDR[IDX_W+1:2];
    end
  end
`else
  logic unused_addr;

  assign start_idx   = '0;
  assign unused_addr = ^REQ_ADDR[IDX_W+1:0];
`endif

  // NOTE: every variable driven here gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    beat_d  = beat_q;
    idx_d   = idx_q;
    case (state_q)
      ST_IDLE: begin
        if (REQ_VALID) begin
          if (req_oor) begin
            state_d = ST_ERROR;
          end else if (LATENCY > 0) begin
            state_d = ST_WAIT;
            wait_d  = CW'(LATENCY - 1);
          end else begin
            state_d = ST_BURST;
            beat_d  = '0;
            idx_d   = start_idx;
          end
        end
      end
      ST_WAIT: begin
        if (wait_q == '0) begin
          state_d = ST_BURST;
          beat_d  = '0;
          idx_d   = start_idx;
        end else begin
          wait_d = wait_q - 1'b1;
        end
      end
      ST_BURST: begin
        beat_d = beat_q + 1'b1;
        idx_d  = idx_q + 1'b1;
        if (last_beat) begin
          state_d = ST_IDLE;
        end
      end
      ST_ERROR: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // The read for a beat is issued on the edge that enters it, so RD_DATA is registered.
  assign rd_load = (state_d == ST_BURST) && !cur_we;
  assign wr_en   = (state_q == ST_BURST) && we_q;

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge MEM_CLK or negedge MEM_RST_N) begin
    if (!MEM_RST_N) begin
      state_q    <= ST_IDLE;
      wait_q     <= '0;
      beat_q     <= '0;
      idx_q      <= '0;
      line_q     <= '0;
      we_q       <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_idx_q   <= '0;
    end else begin
      state_q    <= state_d;
      wait_q     <= wait_d;
      beat_q     <= beat_d;
      idx_q      <= idx_d;
      rd_valid_q <= rd_load;
      rd_idx_q   <= rd_load ? idx_d : '0;
      if (req_fire) begin
        line_q <= req_line;
        we_q   <= REQ_WE;
      end
    end
  end

  // NOTE: the array and its read register have no reset; contents survive MEM_RST_N by design.
  always_ff @(posedge MEM_CLK) begin
    if (wr_en) begin
      mem[{line_q, idx_q}] <= WR_DATA;
    end
    if (rd_load) begin
      ram_q <= mem[{cur_line, idx_d}];
    end
  end

  assign REQ_READY = (state_q == ST_IDLE);
  assign WR_REQ    = wr_en;
  assign WR_IDX    = wr_en ? idx_q : '0;
  assign RD_VALID  = rd_valid_q;
  assign RD_IDX    = rd_idx_q;
  // Gating by the reset-cleared valid gives RD_DATA its reset value without resetting the RAM port.
  assign RD_DATA   = rd_valid_q ? ram_q : '0;
  assign DONE      = (state_q == ST_BURST) && last_beat;
  assign ERR       = (state_q == ST_ERROR);

endmodule

// File: tb/tb_line_fill_mem.sv
// Self-checking bench for line_fill_mem: two instances (LATENCY 4 and 0) against a word-level memory model.
// Honours CRITICAL_WORD_FIRST_EN for the expected read order.

module tb_line_fill_mem;

  localparam int WPL = 8;
  localparam int MW  = 16384;

  logic             mem_clk = 1'b0;
  logic [1:0]       rst_n, req_valid, req_ready, req_we, wr_req, rd_valid, done, err;
  logic [1:0][31:0] req_addr, wr_data, rd_data;
  logic [1:0][2:0]  wr_idx, rd_idx;
  logic [31:0]      line_buf [2][WPL];
  logic [31:0]      model [int];
  int               n_checks = 0;
  int               n_pass   = 0;

  always #5 mem_clk = ~mem_clk;

  // Cache side: drive the writeback word for the index the controller asks for.
  assign wr_data[0] = line_buf[0][wr_idx[0]];
  assign wr_data[1] = line_buf[1][wr_idx[1]];

  line_fill_mem #(.WORDS_PER_LINE(WPL), .LATENCY(4), .MEM_WORDS(MW)) u_dut (
    .MEM_CLK(mem_clk), .MEM_RST_N(rst_n[0]), .REQ_VALID(req_valid[0]), .REQ_READY(req_ready[0]),
    .REQ_WE(req_we[0]), .REQ_ADDR(req_addr[0]), .WR_REQ(wr_req[0]), .WR_IDX(wr_idx[0]),
    .WR_DATA(wr_data[0]), .RD_VALID(rd_valid[0]), .RD_IDX(rd_idx[0]), .RD_DATA(rd_data[0]),
    .DONE(done[0]), .ERR(err[0])
  );

  line_fill_mem #(.WORDS_PER_LINE(WPL), .LATENCY(0), .MEM_WORDS(MW)) u_dut_lat0 (
    .MEM_CLK(mem_clk), .MEM_RST_N(rst_n[1]), .REQ_VALID(req_valid[1]), .REQ_READY(req_ready[1]),
    .REQ_WE(req_we[1]), .REQ_ADDR(req_addr[1]), .WR_REQ(wr_req[1]), .WR_IDX(wr_idx[1]),
    .WR_DATA(wr_data[1]), .RD_VALID(rd_valid[1]), .RD_IDX(rd_idx[1]), .RD_DATA(rd_data[1]),
    .DONE(done[1]), .ERR(err[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
  endtask

  // {ready, wr_req, rd_valid, done, err}
  function automatic logic [31:0] status(input int u);
    return 32'({req_ready[u], wr_req[u], rd_valid[u], done[u], err[u]});
  endfunction

  function automatic int key(input int u, input logic [31:0] word);
    return u * MW + int'(word);
  endfunction

  function automatic int lat_of(input int u);
    return (u == 0) ? 4 : 0;
  endfunction

  // One request from acceptance to the first idle cycle afterwards. With hold set, the next request is
  // presented from T0+1 so it must wait out the busy period. abort_beat >= 0 pulses reset in that beat.
  task automatic run_txn(input int u, input logic we, input logic [31:0] addr, input logic hold,
                         input logic nwe, input logic [31:0] naddr, input int abort_beat);
    int          lat;
    int          start;
    int          j;
    int          idx;
    logic [31:0] base_word;
    logic        oor;
    lat       = lat_of(u);
    base_word = (addr & ~32'h1F) >> 2;
    oor       = (addr & ~32'h1F) >= 32'(MW * 4);
    start     = 0;
`ifdef CRITICAL_WORD_FIRST_EN
    if (!we) start = int'(addr[4:2]);
`endif
    req_valid[u] = 1'b1;
    req_we[u]    = we;
    req_addr[u]  = addr;
    check("ready_before_accept", status(u), 32'b10000);
    @(posedge mem_clk); #1;
    if (hold) begin
      req_we[u]   = nwe;
      req_addr[u] = naddr;
    end else begin
      req_valid[u] = 1'b0;
      req_we[u]    = ~we;
      req_addr[u]  = $urandom;
    end
    if (oor) begin
      check("err_pulse", status(u), 32'b00001);
      @(posedge mem_clk); #1;
      check("err_then_idle", status(u), 32'b10000);
      return;
    end
    for (int k = 1; k <= lat + WPL; k++) begin
      if (k > 1) begin
        @(posedge mem_clk); #1;
      end
      if (k <= lat) begin
        check("wait_quiet", status(u), 32'b00000);
      end else begin
        j = k - lat - 1;
        if (j == abort_beat) begin
          rst_n[u] = 1'b0;
          #1;
          check("rst_status", status(u), 32'b10000);
          check("rst_idx", 32'({wr_idx[u], rd_idx[u]}), 32'h0);
          check("rst_rd_data", rd_data[u], 32'h0);
          @(posedge mem_clk); #1;
          rst_n[u] = 1'b1;
          for (int i = 0; i < j; i++) model[key(u, base_word + 32'(i))] = line_buf[u][i];
          @(posedge mem_clk); #1;
          check("ready_after_rst", status(u), 32'b10000);
          return;
        end
        if (we) begin
          check("wb_status", status(u), {27'b0, 1'b0, 1'b1, 1'b0, (j == WPL - 1), 1'b0});
          check("wr_idx", 32'(wr_idx[u]), 32'(j));
        end else begin
          idx = (start + j) % WPL;
          check("fill_status", status(u), {27'b0, 1'b0, 1'b0, 1'b1, (j == WPL - 1), 1'b0});
          check("rd_idx", 32'(rd_idx[u]), 32'(idx));
          check("rd_data", rd_data[u], model[key(u, base_word + 32'(idx))]);
        end
      end
    end
    @(posedge mem_clk); #1;
    check("idle_after_burst", status(u), 32'b10000);
    if (we) for (int i = 0; i < WPL; i++) model[key(u, base_word + 32'(i))] = line_buf[u][i];
  endtask

  task automatic fill_buf(input int u, input logic [31:0] seed);
    for (int i = 0; i < WPL; i++) line_buf[u][i] = (seed == 0) ? $urandom : seed + 32'(i);
  endtask

  logic [31:0] pool [4] = '{32'h0000_1240, 32'h0000_2000, 32'h0000_3000, 32'h0000_FFE0};

  task automatic pick(output logic we, output logic [31:0] addr);
    int kind;
    kind = $urandom_range(0, 9);
    if (kind == 0) begin
      we   = 1'($urandom_range(0, 1));
      addr = 32'h0001_0000 | $urandom;
    end else begin
      we   = (kind <= 4);
      addr = pool[$urandom_range(0, 3)] | 32'($urandom_range(0, 31));
    end
  endtask

  initial begin
    logic        cur_we, nxt_we, hold;
    logic [31:0] cur_addr, nxt_addr;
    rst_n     = 2'b00;
    req_valid = 2'b00;
    req_we    = 2'b00;
    req_addr  = '0;
    for (int u = 0; u < 2; u++) for (int i = 0; i < WPL; i++) line_buf[u][i] = '0;
    repeat (3) @(posedge mem_clk);
    #1;
    for (int u = 0; u < 2; u++) begin
      check("reset_status", status(u), 32'b10000);
      check("reset_idx", 32'({wr_idx[u], rd_idx[u]}), 32'h0);
      check("reset_rd_data", rd_data[u], 32'h0);
    end
    rst_n = 2'b11;
    @(posedge mem_clk); #1;

    // Writeback then fill of the same line, plus an offset-5 fill of it.
    fill_buf(0, 32'hA0);
    run_txn(0, 1'b1, 32'h0000_1240, 1'b0, 1'b0, 32'h0, -1);
    run_txn(0, 1'b0, 32'h0000_1240, 1'b0, 1'b0, 32'h0, -1);
    run_txn(0, 1'b0, 32'h0000_1254, 1'b0, 1'b0, 32'h0, -1);

    // Zero-latency instance.
    fill_buf(1, 32'h0);
    run_txn(1, 1'b1, 32'h0000_0020, 1'b0, 1'b0, 32'h0, -1);
    run_txn(1, 1'b0, 32'h0000_0020, 1'b1, 1'b0, 32'h0000_003C, -1);
    run_txn(1, 1'b0, 32'h0000_003C, 1'b0, 1'b0, 32'h0, -1);

    // Out of range, including one whose low bits alias line 0x1240; that line must be untouched.
    run_txn(0, 1'b0, 32'h0001_0000, 1'b0, 1'b0, 32'h0, -1);
    fill_buf(0, 32'hDEAD_0000);
    run_txn(0, 1'b1, 32'h0001_1240, 1'b0, 1'b0, 32'h0, -1);
    run_txn(0, 1'b0, 32'h0000_1240, 1'b0, 1'b0, 32'h0, -1);

    // Last in-range line.
    fill_buf(0, 32'h0);
    run_txn(0, 1'b1, 32'h0000_FFE0, 1'b0, 1'b0, 32'h0, -1);
    run_txn(0, 1'b0, 32'h0000_FFFC, 1'b0, 1'b0, 32'h0, -1);

    // Request held while busy: a fill followed by a writeback that waits for the idle cycle.
    run_txn(0, 1'b0, 32'h0000_1240, 1'b1, 1'b1, 32'h0000_2000, -1);
    fill_buf(0, 32'h0);
    run_txn(0, 1'b1, 32'h0000_2000, 1'b0, 1'b0, 32'h0, -1);
    run_txn(0, 1'b0, 32'h0000_2008, 1'b0, 1'b0, 32'h0, -1);

    // Reset during beat 3 of a writeback: words 0-2 new, 3-7 old.
    fill_buf(0, 32'hC0);
    run_txn(0, 1'b1, 32'h0000_3000, 1'b0, 1'b0, 32'h0, -1);
    fill_buf(0, 32'hB0);
    run_txn(0, 1'b1, 32'h0000_3000, 1'b0, 1'b0, 32'h0, 3);
    run_txn(0, 1'b0, 32'h0000_3000, 1'b0, 1'b0, 32'h0, -1);

    // Randomised mix on the LATENCY=4 instance; every pool line has been written by now.
    pick(cur_we, cur_addr);
    for (int n = 0; n < 60; n++) begin
      pick(nxt_we, nxt_addr);
      hold = 1'($urandom_range(0, 1));
      if (cur_we) fill_buf(0, 32'h0);
      run_txn(0, cur_we, cur_addr, hold, nxt_we, nxt_addr, -1);
      cur_we   = nxt_we;
      cur_addr = nxt_addr;
    end

    // Randomised fills on the zero-latency instance.
    for (int n = 0; n < 10; n++) begin
      cur_we = 1'($urandom_range(0, 1));
      if (cur_we) fill_buf(1, 32'h0);
      run_txn(1, cur_we, 32'h0000_0020 | 32'($urandom_range(0, 31)), 1'b0, 1'b0, 32'h0, -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/line_fill_mem.md
Name: line_fill_mem

Overview:
Backing-store controller that sits directly below the 2-way data cache in OtterMemory.
- Services line-fill requests (cache read miss) and line-writeback requests (dirty eviction) as 8-word bursts.
- Models main-memory access latency with a programmable wait counter.
- Holds a word-addressed RAM array and flags out-of-range accesses.

Parameters:
WORDS_PER_LINE, 8, words per cache line; must be a power of 2 (index width IDX_W = log2).
LATENCY, 4, wait cycles between request acceptance and first beat; 0 is legal.
MEM_WORDS, 16384, depth of the RAM array in 32-bit words.

Ports:
MEM_CLK  in  1  clock; all state updates on rising edge.
MEM_RST_N  in  1  asynchronous, active-low reset.
REQ_VALID  in  1  cache presents a request.
REQ_READY  out  1  controller idle and accepts a request this cycle.
REQ_WE  in  1  1 = writeback line, 0 = fill line.
REQ_ADDR  in  32  byte address. Line base = REQ_ADDR with the low log2(WORDS_PER_LINE)+2 bits cleared. Word offset = REQ_ADDR[IDX_W+1:2].
WR_REQ  out  1  write beat active; cache must drive WR_DATA combinationally for WR_IDX this cycle.
WR_IDX  out  IDX_W  word index within the line for the current write beat.
WR_DATA  in  32  writeback word, written into the array at the rising edge ending the beat.
RD_VALID  out  1  read beat valid.
RD_IDX  out  IDX_W  word index within the line for RD_DATA.
RD_DATA  out  32  fill word (registered).
DONE  out  1  one-cycle pulse coincident with the final beat of a burst.
ERR  out  1  one-cycle pulse: request line base is >= MEM_WORDS*4; no transfer occurs.

Behaviour:
- Reset (MEM_RST_N low, asynchronous):
  - FSM goes to IDLE.
  - REQ_READY=1. WR_REQ, RD_VALID, DONE, ERR = 0. WR_IDX, RD_IDX, RD_DATA = 0.
  - RAM array is NOT cleared.
- FSM states: IDLE, WAIT, BURST, ERROR.
- IDLE:
  - REQ_READY=1.
  - Handshake occurs on the edge where REQ_VALID && REQ_READY. At that edge, latch line base, word offset and REQ_WE.
  - If the address is out of range, go to ERROR.
  - Else if LATENCY>0: load the wait counter with LATENCY-1 and go to WAIT.
  - Else go to BURST.
- WAIT:
  - REQ_READY=0. Counter decrements each cycle.
  - Go to BURST on the edge where the counter is 0.
  - Exactly LATENCY cycles are spent in WAIT.
- BURST:
  - REQ_READY=0. Exactly WORDS_PER_LINE consecutive beats, one per cycle, no gaps. Beat counter runs 0..WORDS_PER_LINE-1.
  - Read: RD_VALID=1 and RD_DATA=array[base_word+RD_IDX] for each beat.
  - Write: WR_REQ=1; array[base_word+WR_IDX] <= WR_DATA at the end of each beat.
  - DONE=1 during the last beat. Return to IDLE at the next edge; REQ_READY=1 in the following cycle.
- Timing, with acceptance at edge T0:
  - Beats occupy cycles T0+LATENCY+1 through T0+LATENCY+WORDS_PER_LINE.
  - Total busy cycles = LATENCY + WORDS_PER_LINE.
- ERROR: ERR=1 for exactly one cycle (cycle after acceptance), then IDLE. No DONE, no beats, no array write.
- Requests presented while busy are ignored because REQ_READY=0. REQ_VALID must be held by the cache until accepted.
- REQ_ADDR and REQ_WE are sampled only at acceptance; later changes have no effect on the current burst.
- Reset asserted mid-burst: immediate return to IDLE. Words already written remain; the rest of the line is unchanged. No DONE.
- Address arithmetic:
  - base_word = line base >> 2.
  - Beat index wraps modulo WORDS_PER_LINE and never carries into the line base.

Optional Feature:
CRITICAL_WORD_FIRST_EN
- Defined: read bursts start at the latched word offset and wrap modulo WORDS_PER_LINE. Example: offset 5 gives order 5,6,7,0,1,2,3,4. RD_IDX reports the true index. DONE is on the 8th beat.
- Writes always go 0..7 in both builds.
- Undefined: read bursts always start at index 0; the offset is ignored.

Test Plan:
- Reset mid-burst: assert MEM_RST_N=0 during beat 3 of a writeback -> outputs return to reset values immediately; words 0-2 updated, 3-7 unchanged; REQ_READY=1 after release.
- Writeback then fill, LATENCY=4, addr 0x0000_1240: write words 0xA0..0xA7 -> WR_REQ high 8 cycles starting T0+5, DONE on the 8th; then fill -> RD_DATA 0xA0..0xA7 with RD_IDX 0..7, first beat at T0+5.
- LATENCY=0, fill at 0x0000_0020 -> first RD_VALID in cycle T0+1; REQ_READY low exactly 8 cycles.
- Out of range, MEM_WORDS=16384, fill at 0x0001_0000 -> ERR pulses 1 cycle at T0+1; no RD_VALID, no DONE; REQ_READY=1 at T0+2.
- Busy ignore: second REQ_VALID held from T0+1 -> not accepted until the IDLE cycle after DONE; then serviced normally.
- CRITICAL_WORD_FIRST_EN defined, fill at 0x0000_1254 (offset 5) -> RD_IDX sequence 5,6,7,0,1,2,3,4 with matching data; undefined -> 0..7.
